// File: rtl/mem1_stage_pkg.sv
// Shared types and constants for the MEM1 stage: bus layouts, LSU op bit
// positions, stall vector indices and the byte-offset helper.
package mem1_stage_pkg;

  localparam int EX2MEM1_WD   = 182;
  localparam int MEM12MEM2_WD = 166;
  localparam int MEM12ID_WD   = 70;

  localparam int STALL_WD   = 6;
  localparam int STALL_MEM1 = 4;  // hold the EX->MEM1 register
  localparam int STALL_MEM2 = 5;  // hold the MEM1->MEM2 register

  // lsu_op = {ld, st, uns, sz_d, sz_w, sz_h, sz_b}
  localparam int LSU_SZ_B = 0;
  localparam int LSU_SZ_H = 1;
  localparam int LSU_SZ_W = 2;
  localparam int LSU_SZ_D = 3;
  localparam int LSU_UNS  = 4;
  localparam int LSU_ST   = 5;
  localparam int LSU_LD   = 6;

  typedef struct packed {
    logic [6:0]  lsu_op;
    logic [7:0]  data_ram_sel;
    logic        is_load;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] ex_result;
    logic [63:0] pc;
    logic [31:0] inst;
  } ex2mem1_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] wb_data;
    logic [63:0] pc;
    logic [31:0] inst;
  } mem12mem2_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] wb_data;
  } mem12id_t;

  // Byte offset = index of the lowest set lane in the byte-select mask.
  // An empty mask maps to offset 0.
  function automatic logic [2:0] sel2off(input logic [7:0] sel);
    logic [2:0] off;
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (sel[i]) off = 3'(i);
    end
    return off;
  endfunction

endpackage

// File: rtl/mem1_stage_load_align.sv
// Load aligner: shifts the addressed bytes down to bit 0 and extends them
// to 64 bits according to the access size and signedness.
module mem1_stage_load_align
  import mem1_stage_pkg::*;
(
  input  logic [63:0] eff,
  input  logic [7:0]  data_ram_sel,
  input  logic [6:0]  lsu_op,
  output logic [63:0] load_data
);

  logic [5:0]  shamt;
  logic [63:0] sh;
  logic        uns;
  logic        unused_lsu;

  // Ld/st class bits are decoded upstream; only size and signedness matter here.
  assign unused_lsu = ^{lsu_op[LSU_LD], lsu_op[LSU_ST]};
  assign uns        = lsu_op[LSU_UNS];

  // Align to the lowest selected byte, then size-select and extend.
  always_comb begin
    shamt     = {sel2off(data_ram_sel), 3'b000};
    sh        = eff >> shamt;
    load_data = sh;
    if (lsu_op[LSU_SZ_B])
      load_data = {{56{~uns & sh[7]}}, sh[7:0]};
    else if (lsu_op[LSU_SZ_H])
      load_data = {{48{~uns & sh[15]}}, sh[15:0]};
    else if (lsu_op[LSU_SZ_W])
      load_data = {{32{~uns & sh[31]}}, sh[31:0]};
    else if (lsu_op[LSU_SZ_D])
      load_data = sh;
  end

endmodule

// File: rtl/mem1_stage.sv
// MEM1 pipeline stage: latches the EX bundle, captures SRAM read data in the
// bundle's first cycle so it survives stalls, aligns loads and drives the
// MEM2 and ID-forwarding buses combinationally from the stage register.
module mem1_stage
  import mem1_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX2MEM1_WD-1:0]   ex2mem1_bus,
  input  logic [63:0]             data_sram_rdata,
  output logic [MEM12MEM2_WD-1:0] mem12mem2_bus,
  output logic [MEM12ID_WD-1:0]   mem12id_fwd
);

  ex2mem1_t    bus_q, bus_d;
  logic        fresh_q, fresh_d;
  logic [63:0] hold_rdata_q, hold_rdata_d;
  logic        hold_vld_q, hold_vld_d;

  logic        bubble;
  logic        bus_upd;
  logic [63:0] eff;
  logic [63:0] load_data;
  logic [63:0] wb_data;
  mem12mem2_t  m2;
  mem12id_t    fwd;

  // Downstream free but MEM1 held: push a bubble instead of duplicating.
  assign bubble  = stall[STALL_MEM1] & ~stall[STALL_MEM2];
  // Register changes unless both MEM1 and MEM2 are held.
  assign bus_upd = ~stall[STALL_MEM1] | ~stall[STALL_MEM2];

  // Stage register and fresh flag next-state.
  always_comb begin
    bus_d   = bus_q;
    fresh_d = 1'b0;
    if (!rst_n || flush || bubble) begin
      bus_d = '0;
    end else if (!stall[STALL_MEM1]) begin
      bus_d   = ex2mem1_t'(ex2mem1_bus);
      fresh_d = |ex2mem1_bus;
    end
  end

  // Capture live SRAM data once so a stalled load keeps a stable copy.
  always_comb begin
    hold_rdata_d = hold_rdata_q;
    hold_vld_d   = hold_vld_q;
    if (!rst_n) begin
      hold_rdata_d = '0;
      hold_vld_d   = 1'b0;
    end else if (flush || bus_upd) begin
      hold_vld_d   = 1'b0;
    end else if (fresh_q && bus_q.is_load) begin
      hold_rdata_d = data_sram_rdata;
      hold_vld_d   = 1'b1;
    end
  end

  // State registers; reset is folded into the next-state logic.
  always_ff @(posedge clk) begin
    bus_q        <= bus_d;
    fresh_q      <= fresh_d;
    hold_rdata_q <= hold_rdata_d;
    hold_vld_q   <= hold_vld_d;
  end

  // Live SRAM output is only trusted in the bundle's first cycle.
  assign eff = fresh_q    ? data_sram_rdata :
               hold_vld_q ? hold_rdata_q    : '0;

  mem1_stage_load_align u_load_align (
    .eff          (eff),
    .data_ram_sel (bus_q.data_ram_sel),
    .lsu_op       (bus_q.lsu_op),
    .load_data    (load_data)
  );

  assign wb_data = bus_q.is_load ? load_data : bus_q.ex_result;

  // Output bundles, purely combinational from the stage register.
  always_comb begin
    m2.rf_we     = bus_q.rf_we;
    m2.rf_waddr  = bus_q.rf_waddr;
    m2.wb_data   = wb_data;
    m2.pc        = bus_q.pc;
    m2.inst      = bus_q.inst;
    fwd.rf_we    = bus_q.rf_we;
    fwd.rf_waddr = bus_q.rf_waddr;
    fwd.wb_data  = wb_data;
  end

  assign mem12mem2_bus = m2;
  assign mem12id_fwd   = fwd;

endmodule

// File: tb/tb_mem1_stage.sv
// Bench for mem1_stage: directed scenarios plus random traffic against a
// bundle-level reference model (each bundle owns the SRAM data seen in its
// first MEM1 cycle).
module tb_mem1_stage;
  import mem1_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n, flush;
  logic [5:0]   stall;
  logic [181:0] ex_bus;
  logic [63:0]  rdata;
  logic [165:0] m2;
  logic [69:0]  fwd;

  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem1_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .stall           (stall),
    .ex2mem1_bus     (ex_bus),
    .data_sram_rdata (rdata),
    .mem12mem2_bus   (m2),
    .mem12id_fwd     (fwd)
  );

  localparam logic [6:0] OP_ALU = 7'b0000000;
  localparam logic [6:0] OP_SD  = 7'b0101000;
  localparam logic [6:0] OP_LD  = 7'b1001000;
  localparam logic [6:0] OP_LW  = 7'b1000100;
  localparam logic [6:0] OP_LWU = 7'b1010100;
  localparam logic [6:0] OP_LH  = 7'b1000010;
  localparam logic [6:0] OP_LHU = 7'b1010010;
  localparam logic [6:0] OP_LB  = 7'b1000001;
  localparam logic [6:0] OP_LBU = 7'b1010001;
  localparam logic [181:0] NOP  = '0;

  task automatic chk(input string tag, input logic [165:0] got, input logic [165:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: current bundle, whether it just arrived, and its data.
  ex2mem1_t    m_b = '0;
  logic        m_fresh = 1'b0;
  logic [63:0] m_data = '0;

  function automatic logic [63:0] ref_load(input logic [6:0] op, input logic [7:0] sel,
                                           input logic [63:0] rd);
    int off = 0, n;
    logic found = 1'b0;
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++)
      if (sel[i] && !found) begin off = i; found = 1'b1; end
    n = op[0] ? 1 : op[1] ? 2 : op[2] ? 4 : 8;
    for (int k = 0; k < n; k++)
      if (off + k < 8) v[8*k +: 8] = rd[8*(off+k) +: 8];
    if (!op[4] && n < 8 && v[8*n-1])
      for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [165:0] ref_out(input ex2mem1_t b, input logic [63:0] rd);
    logic [63:0] wb;
    wb = b.is_load ? ref_load(b.lsu_op, b.data_ram_sel, rd) : b.ex_result;
    return {b.rf_we, b.rf_waddr, wb, b.pc, b.inst};
  endfunction

  function automatic logic [181:0] mk(input logic [6:0] op, input logic [7:0] sel,
                                      input logic [4:0] wa, input logic [63:0] exr);
    ex2mem1_t t;
    t.lsu_op       = op;
    t.data_ram_sel = sel;
    t.is_load      = op[6];
    t.rf_we        = ~op[5];
    t.rf_waddr     = wa;
    t.ex_result    = exr;
    t.pc           = {$urandom, $urandom} | 64'd1;
    t.inst         = $urandom;
    return t;
  endfunction

  function automatic logic [181:0] rnd_bundle();
    int k, n, off;
    logic [6:0] op;
    logic [7:0] sel;
    logic [7:0] full = 8'hFF;
    k = $urandom_range(0, 11);
    case (k)
      0, 1:    op = OP_ALU;
      2:       op = OP_SD;
      3:       op = OP_LD;
      4:       op = OP_LW;
      5:       op = OP_LWU;
      6:       op = OP_LH;
      7:       op = OP_LHU;
      8:       op = OP_LB;
      9:       op = OP_LBU;
      default: return NOP;
    endcase
    n   = op[0] ? 1 : op[1] ? 2 : op[2] ? 4 : 8;
    off = $urandom_range(0, 8/n - 1) * n;
    sel = (full >> (8 - n)) << off;
    if (op == OP_ALU || $urandom_range(0, 7) == 0) sel = 8'h00;
    return mk(op, sel, 5'($urandom), {$urandom, $urandom});
  endfunction

  logic [165:0] obs_m2;
  logic [69:0]  obs_fwd;
  logic         obs_hv;

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic cyc(input logic r, input logic f, input logic [5:0] st,
                     input logic [181:0] b, input logic [63:0] rd);
    logic [165:0] e;
    @(negedge clk);
    rst_n = r; flush = f; stall = st; ex_bus = b; rdata = rd;
    #1;
    obs_m2 = m2; obs_fwd = fwd; obs_hv = dut.hold_vld_q;
    e = ref_out(m_b, m_fresh ? rd : m_data);
    chk("m2bus", m2, e);
    chk("fwd", 166'(fwd), 166'(e[165:96]));
    @(posedge clk);
    if (!r) begin
      m_b = '0; m_fresh = 1'b0; m_data = '0;
    end else begin
      if (m_fresh && st[4] && st[5] && !f) m_data = rd;
      if (f || (st[4] && !st[5])) begin
        m_b = '0; m_fresh = 1'b0;
      end else if (!st[4]) begin
        m_b = ex2mem1_t'(b); m_fresh = (b != '0);
      end else begin
        m_fresh = 1'b0;
      end
    end
  endtask

  logic [181:0] b1, b2;
  logic [5:0]   rst_pick;

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = '0; ex_bus = '0; rdata = '0;
    repeat (2) @(posedge clk);

    // reset state
    cyc(0, 0, 0, NOP, 64'h0);
    chk("rst_m2", obs_m2, '0);
    chk("rst_fwd", 166'(obs_fwd), '0);

    // 1: ld doubleword
    cyc(1, 0, 0, mk(OP_LD, 8'hFF, 5'd3, 64'h1234), 64'h0);
    cyc(1, 0, 0, NOP, 64'h8877665544332211);
    chk("t1_wb", 166'(obs_m2[159:96]), 166'(64'h8877665544332211));
    chk("t1_we", 166'(obs_m2[165]), 166'(1));
    chk("t1_fwd", 166'(obs_fwd[63:0]), 166'(64'h8877665544332211));

    // 2: lb / lbu from byte 3
    cyc(1, 0, 0, mk(OP_LB, 8'h08, 5'd4, 64'h0), 64'h0);
    cyc(1, 0, 0, mk(OP_LBU, 8'h08, 5'd5, 64'h0), 64'h0000000080000000);
    chk("t2_lb", 166'(obs_m2[159:96]), 166'(64'hFFFFFFFFFFFFFF80));
    cyc(1, 0, 0, NOP, 64'h0000000080000000);
    chk("t2_lbu", 166'(obs_m2[159:96]), 166'(64'h80));

    // 3: lw held across stalls while SRAM output changes
    cyc(1, 0, 0, mk(OP_LW, 8'hF0, 5'd6, 64'h0), 64'h0);
    cyc(1, 0, 6'h30, NOP, 64'h89ABCDEF00000000);
    chk("t3_c0", 166'(obs_m2[159:96]), 166'(64'hFFFFFFFF89ABCDEF));
    for (int i = 1; i < 3; i++) begin
      cyc(1, 0, 6'h30, NOP, 64'h0);
      chk("t3_stall", 166'(obs_m2[159:96]), 166'(64'hFFFFFFFF89ABCDEF));
    end
    cyc(1, 0, 0, NOP, 64'h0);
    chk("t3_rel", 166'(obs_m2[159:96]), 166'(64'hFFFFFFFF89ABCDEF));

    // 4: bubble then pass-through
    b1 = mk(OP_ALU, 8'h00, 5'd7, 64'hAAAA);
    b2 = mk(OP_ALU, 8'h00, 5'd8, 64'hBBBB_CCCC_DDDD_EEEE);
    cyc(1, 0, 0, b1, 64'h5555);
    cyc(1, 0, 6'h10, b2, 64'h0);
    cyc(1, 0, 0, b2, 64'h0);
    chk("t4_bubble", obs_m2, '0);
    chk("t4_bubble_fwd", 166'(obs_fwd), '0);
    cyc(1, 0, 0, NOP, 64'h0);
    chk("t4_pass", obs_m2, {1'b1, 5'd8, 64'hBBBB_CCCC_DDDD_EEEE, b2[95:0]});

    // 5: flush during a held load, then lhu
    cyc(1, 0, 0, mk(OP_LW, 8'h0F, 5'd9, 64'h0), 64'h0);
    cyc(1, 0, 6'h30, NOP, 64'h1111222280000000);
    cyc(1, 1, 6'h30, NOP, 64'h0);
    chk("t5_hvld_set", 166'(obs_hv), 166'(1));
    cyc(1, 0, 0, mk(OP_LHU, 8'h0C, 5'd10, 64'h0), 64'h0);
    chk("t5_flush", obs_m2, '0);
    chk("t5_hvld_clr", 166'(obs_hv), '0);
    cyc(1, 0, 0, NOP, 64'h00000000BEEF0000);
    chk("t5_lhu", 166'(obs_m2[159:96]), 166'(64'hBEEF));

    // 6: reset mid-stall, then an add passes through
    cyc(1, 0, 0, mk(OP_LD, 8'hFF, 5'd11, 64'h0), 64'h0);
    cyc(1, 0, 6'h30, NOP, 64'hDEAD_BEEF_0BAD_F00D);
    cyc(0, 0, 6'h30, NOP, 64'h0);
    cyc(1, 0, 0, mk(OP_ALU, 8'h00, 5'd12, 64'h0123_4567_89AB_CDEF), 64'h0);
    chk("t6_rst", obs_m2, '0);
    cyc(1, 0, 0, NOP, 64'hFFFF);
    chk("t6_add", 166'(obs_m2[159:96]), 166'(64'h0123_4567_89AB_CDEF));
    chk("t6_we", 166'(obs_m2[165]), 166'(1));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] st;
      case ($urandom_range(0, 7))
        0:       st = 6'h30;
        1:       st = 6'h10;
        2:       st = 6'h20;
        default: st = 6'h00;
      endcase
      rst_pick = 6'($urandom);
      cyc(rst_pick != 6'd0, $urandom_range(0, 31) == 0, st, rnd_bundle(),
          {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
